// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared gate-select encoding for the logic unit.
// Op order matches the y[0..6] bit order of the basic-gates block.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational bitwise gate, (a, b, op) -> (y, err).
// Ports: a, b operands; op gate select; y result; err reserved op.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    unique case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_RSVD: err = 1'b1;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready gate pipe with accumulator,
// flags (zero/parity/err) and completed-handshake counter.
// Ports: clk, rst (sync, high); in_valid/in_ready, a, b, op, acc_en;
// out_valid/out_ready, y, zero, parity, err; txn_count.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             err,
  output logic [CNT_W-1:0] txn_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] a_s1;
  logic [WIDTH-1:0] b_s1;
  op_e              op_s1;
  logic             acc_en_s1;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res;
  logic             res_err;
  logic             accept;
  logic             compute;
  logic             drain;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign compute  = s1_valid && (!out_valid || out_ready);
  assign drain    = out_valid && out_ready;
  assign opa      = acc_en_s1 ? acc : a_s1;

  logic_unit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (opa),
    .b  (b_s1),
    .op (op_s1),
    .y  (res),
    .err(res_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      a_s1      <= '0;
      b_s1      <= '0;
      op_s1     <= OP_NOT;
      acc_en_s1 <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        a_s1      <= a;
        b_s1      <= b;
        op_s1     <= op_e'(op);
        acc_en_s1 <= acc_en;
      end else if (compute) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  // acc follows every computed result so acc_en beats chain bubble-free
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
    end else begin
      if (compute) begin
        out_valid <= 1'b1;
        y         <= res;
        zero      <= (res == '0);
        parity    <= ^res;
        err       <= res_err;
        acc       <= res;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (drain) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

- Parametrised, pipelined successor to the two-input basic-gates block.
- Applies one selectable bitwise gate (NOT, AND, OR, NAND, NOR, XOR, XNOR) to WIDTH-bit operands.
- Adds valid/ready flow control, an accumulate mode that chains results, result flags and a completed-transaction counter.
- Sits between an operand source and a result consumer as a small logic-execution stage.

## Interface
- WIDTH, 8: operand and result width in bits, ≥1.
- CNT_W, 16: transaction counter width.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  gate select.
- acc_en  input  1  use the accumulator instead of `a` as operand A.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result.
- zero  output  1  y == 0.
- parity  output  1  XOR-reduction of y.
- err  output  1  op was reserved (7).
- txn_count  output  CNT_W  number of completed output handshakes.

## Operation
- Gate select by op: 0 NOT a (b ignored), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved (y = 0, err = 1).
- The op ordering matches bit ordering y[0..6] of the basic-gates block.
- Input handshake: a beat is accepted when in_valid && in_ready.
  - a, b, op and acc_en are captured into stage 1 at that edge.
- Stage 1 → stage 2 (compute) when s1_valid && (!s2_valid || out_ready).
  - Operand A = acc_en ? acc : a_s1.
  - The result and flags register into stage 2.
- At that same compute edge, acc is loaded with the new result, for every op including 7.
  - Back-to-back acc_en beats therefore chain correctly with no bubble.
- Output handshake: completes when out_valid && out_ready.
  - txn_count increments by 1 per completed handshake and wraps modulo 2^CNT_W.
- in_ready = !s1_valid || !s2_valid || out_ready. This is combinational and does not depend on in_valid.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous output handshake and compute: stage 2 is replaced by the new result that cycle, so out_valid stays 1.
- Simultaneous input accept and compute: stage 1 is reloaded and its valid stays 1.
- Reset values: in_ready 1, out_valid 0, y 0, zero 0, parity 0, err 0, txn_count 0.
  - Internal reset: acc 0, s1_valid 0.
- Reset mid-operation discards all in-flight beats and clears acc; no partial result is emitted.

## Timing
- Latency from accepted input to out_valid is 2 cycles when unstalled.
  - Accepted at edge N, compute at edge N+1, out_valid high after edge N+1, consumed at edge N+2.
- Throughput is 1 beat per cycle with out_ready held high.
- Stalling: with out_ready low, up to 2 beats are held (stage 1 + stage 2). in_ready then falls to 0.
- in_ready returns to 1 in the same cycle out_ready rises.
- The first accept is possible in the cycle after rst deasserts.
- zero, parity and err are registered alongside y and always describe the y currently presented.

## Structure
- Shared package logic_unit_pkg:
  - Op enum: OP_NOT=0, OP_AND=1, OP_OR=2, OP_NAND=3, OP_NOR=4, OP_XOR=5, OP_XNOR=6, OP_RSVD=7.
  - Op width constant OP_W=3.
- One natural sub-module, logic_unit_core: purely combinational (a, b, op) → (y, err), parametrised by WIDTH.
  - It is reused by the existing gate bench for exhaustive checks.
- Top level holds both stage registers, the accumulator, handshake logic, flags and the counter.

## Test plan
- Exhaustive 1-bit sweep, WIDTH=1, out_ready=1: all a, b ∈ {0,1}, op 0–6 → y matches the gate truth table; err=0; each result appears 2 cycles after its accept.
- WIDTH=8 single beats:
  - a=0xF0, b=0x3C → op1 gives 0x30, op5 gives 0xCC, op6 gives 0x33, op0 gives 0x0F.
  - op3 with a=b=0xFF gives 0x00 with zero=1, parity=0.
- Accumulate chain after reset (acc=0):
  - Beat 1: op2, b=0x01 → y=0x01.
  - Beat 2: acc_en=1, op5, b=0x03 → y=0x02.
  - Beat 3: acc_en=1, op0 → y=0xFD with parity=1.
  - All three back-to-back with no bubbles.
- Backpressure: stream 4 beats with out_ready=0.
  - in_ready drops after 2 accepts.
  - With out_ready=1, results emerge in order, held stable while stalled.
  - txn_count reaches 4.
- Reserved op: op=7 → y=0x00, err=1, zero=1; the next valid op clears err.
- Reset mid-stream: assert rst with 2 beats in flight → next cycle out_valid=0, txn_count=0, in_ready=1; a following acc_en op1, b=0xFF yields 0x00.
